chess_turn_controller: RTL and testbench
========================================

Name: chess_turn_controller

Overview:
- Upstream control stage for the chess clock. Drives the two player timer stages.
- Decides which player's clock runs from player move buttons and a start/pause button.
- Divides the system clock down to a 1 Hz one-cycle count pulse, routed only to the active player's timer.
- Watches both timers' expiry flags and latches the loser's flag.

Parameters:
- TICK_DIV, 100000000: system clock cycles per count pulse. Must be ≥2. Benches use 4.
- CNT_W, $clog2(TICK_DIV): prescaler width, derived. Not overridden.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- START  in  1  start/pause button level, asynchronous to CLK.
- BTN_P1  in  1  player 1 "move done" button level, asynchronous.
- BTN_P2  in  1  player 2 "move done" button level, asynchronous.
- OVF_P1  in  1  player 1 timer expired (level, CLK domain).
- OVF_P2  in  1  player 2 timer expired (level, CLK domain).
- IMPULSE_P1  out  1  one-cycle count pulse to player 1 timer.
- IMPULSE_P2  out  1  one-cycle count pulse to player 2 timer.
- ACTIVE_P1  out  1  player 1 owns the move (LED).
- ACTIVE_P2  out  1  player 2 owns the move (LED).
- RUNNING  out  1  a clock is currently counting.
- FLAG_P1  out  1  player 1 lost on time, sticky.
- FLAG_P2  out  1  player 2 lost on time, sticky.

Behaviour:
- Reset: CLR high asynchronously forces state IDLE, prescaler 0, synchronizers 0, all outputs 0. No clock edge is needed. Effective mid-operation in any state.
- Inputs: START, BTN_P1 and BTN_P2 each pass through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - Level held high produces exactly one event.
  - Latency from first sampled high to the state change visible on outputs is 3 CLK cycles.
- OVF inputs are used directly, as levels.
- All outputs are registered.
- States: IDLE, RUN_P1, RUN_P2, PAUSED, TIMEOUT. A 1-bit register `who` records the paused player.
- IDLE:
  - START event → RUN_P1 (player 1 moves first), prescaler 0.
  - BTN events ignored.
- RUN_P1:
  - OVF_P1=1 → TIMEOUT, FLAG_P1←1.
  - Else START event → PAUSED, who←P1.
  - Else BTN_P1 event → RUN_P2, prescaler←0.
  - BTN_P2 ignored.
- RUN_P2: mirror image of RUN_P1 (OVF_P2, BTN_P2, who←P2).
- Priority within one cycle: OVF > START > own BTN.
- PAUSED:
  - Prescaler frozen, holds its value.
  - START event → RUN_P1 or RUN_P2 per `who`.
  - Counting resumes from the held prescaler value.
  - BTN and OVF ignored.
- TIMEOUT: absorbing. All inputs ignored until CLR. FLAG stays 1.
- Prescaler:
  - Counts only in RUN_P1 or RUN_P2: 0..TICK_DIV-1, then wraps to 0.
  - On the cycle the count equals TICK_DIV-1 (and the state is unchanged), the IMPULSE of the active player is 1 for exactly one cycle.
  - The other IMPULSE is always 0.
  - First pulse after entering RUN from IDLE or a switch comes TICK_DIV cycles later.
  - A switch occurring on the wrap cycle suppresses that pulse.
- Outputs:
  - ACTIVE_P1=1 in RUN_P1, in PAUSED with who=P1, and in TIMEOUT with FLAG_P1. ACTIVE_P2 is symmetric.
  - In IDLE both ACTIVE outputs are 0.
  - RUNNING=1 only in RUN_P1 or RUN_P2.
  - Never are both ACTIVE outputs, both IMPULSE outputs, or both FLAG outputs 1 at once.

Test Plan (TICK_DIV=4):
1. CLR pulse, then START high 5 cycles → ACTIVE_P1=1 and RUNNING=1 three cycles after sampling. IMPULSE_P1 pulses every 4th cycle, one cycle wide. IMPULSE_P2 stays 0. One event only.
2. In RUN_P1, BTN_P2 press → no change. BTN_P1 press mid-count → ACTIVE_P2=1, ACTIVE_P1=0. First IMPULSE_P2 arrives exactly 4 cycles after the switch.
3. In RUN_P2 after 2 prescaler counts, START press → RUNNING=0, ACTIVE_P2=1, no impulses for 20 cycles, BTN_P2 ignored. START again → RUNNING=1, IMPULSE_P2 after 2 remaining cycles.
4. In RUN_P1, OVF_P1=1 → FLAG_P1=1, RUNNING=0, no further impulses. START and BTN presses ignored over 30 cycles. CLR → all outputs 0, state IDLE.
5. In RUN_P2, OVF_P2, START event and BTN_P2 event in the same cycle → TIMEOUT, FLAG_P2=1, FLAG_P1=0.
6. CLR asserted between clock edges during RUN_P1 → all outputs 0 before the next CLK edge. After release, a BTN press has no effect until START.

Source files
------------

// File: rtl/chess_turn_controller.sv
// Turn controller for a two-player chess clock: synchronizes the buttons, decides whose
// clock runs, prescales CLK to one count pulse per TICK_DIV cycles and latches the loser.
module chess_turn_controller #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic CLK,
  input  logic CLR,
  input  logic START,
  input  logic BTN_P1,
  input  logic BTN_P2,
  input  logic OVF_P1,
  input  logic OVF_P2,
  output logic IMPULSE_P1,
  output logic IMPULSE_P2,
  output logic ACTIVE_P1,
  output logic ACTIVE_P2,
  output logic RUNNING,
  output logic FLAG_P1,
  output logic FLAG_P2
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN_P1  = 3'd1,
    S_RUN_P2  = 3'd2,
    S_PAUSED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  logic             r_who;
  logic             r_flag_p1;
  logic             r_flag_p2;
  logic [CNT_W-1:0] r_cnt;

  // Two synchronizer stages plus one edge-detect stage per button.
  logic r_start_s1, r_start_s2, r_start_s3;
  logic r_btn1_s1, r_btn1_s2, r_btn1_s3;
  logic r_btn2_s1, r_btn2_s2, r_btn2_s3;

  logic r_impulse_p1, r_impulse_p2;
  logic r_active_p1, r_active_p2;
  logic r_running;

  state_t           w_next_state;
  logic             w_next_who;
  logic             w_next_flag_p1;
  logic             w_next_flag_p2;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_wrap;
  logic             w_start_ev;
  logic             w_btn1_ev;
  logic             w_btn2_ev;
  logic             w_run_now;
  logic             w_run_next;

  logic w_impulse_p1, w_impulse_p2;
  logic w_active_p1, w_active_p2;
  logic w_running;

  assign w_start_ev = r_start_s2 & ~r_start_s3;
  assign w_btn1_ev  = r_btn1_s2 & ~r_btn1_s3;
  assign w_btn2_ev  = r_btn2_s2 & ~r_btn2_s3;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state      <= S_IDLE;
      r_who        <= 1'b0;
      r_flag_p1    <= 1'b0;
      r_flag_p2    <= 1'b0;
      r_cnt        <= '0;
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_s3   <= 1'b0;
      r_btn1_s1    <= 1'b0;
      r_btn1_s2    <= 1'b0;
      r_btn1_s3    <= 1'b0;
      r_btn2_s1    <= 1'b0;
      r_btn2_s2    <= 1'b0;
      r_btn2_s3    <= 1'b0;
      r_impulse_p1 <= 1'b0;
      r_impulse_p2 <= 1'b0;
      r_active_p1  <= 1'b0;
      r_active_p2  <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_who        <= w_next_who;
      r_flag_p1    <= w_next_flag_p1;
      r_flag_p2    <= w_next_flag_p2;
      r_cnt        <= w_next_cnt;
      r_start_s1   <= START;
      r_start_s2   <= r_start_s1;
      r_start_s3   <= r_start_s2;
      r_btn1_s1    <= BTN_P1;
      r_btn1_s2    <= r_btn1_s1;
      r_btn1_s3    <= r_btn1_s2;
      r_btn2_s1    <= BTN_P2;
      r_btn2_s2    <= r_btn2_s1;
      r_btn2_s3    <= r_btn2_s2;
      r_impulse_p1 <= w_impulse_p1;
      r_impulse_p2 <= w_impulse_p2;
      r_active_p1  <= w_active_p1;
      r_active_p2  <= w_active_p2;
      r_running    <= w_running;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_who     = r_who;
    w_next_flag_p1 = r_flag_p1;
    w_next_flag_p2 = r_flag_p2;
    w_next_cnt     = r_cnt;
    w_wrap         = 1'b0;

    // Priority inside a running state: expiry, then pause, then own move button.
    case (r_state)
      S_IDLE: begin
        if (w_start_ev) w_next_state = S_RUN_P1;
      end
      S_RUN_P1: begin
        if (OVF_P1) begin
          w_next_state   = S_TIMEOUT;
          w_next_flag_p1 = 1'b1;
        end else if (w_start_ev) begin
          w_next_state = S_PAUSED;
          w_next_who   = 1'b0;
        end else if (w_btn1_ev) begin
          w_next_state = S_RUN_P2;
        end
      end
      S_RUN_P2: begin
        if (OVF_P2) begin
          w_next_state   = S_TIMEOUT;
          w_next_flag_p2 = 1'b1;
        end else if (w_start_ev) begin
          w_next_state = S_PAUSED;
          w_next_who   = 1'b1;
        end else if (w_btn2_ev) begin
          w_next_state = S_RUN_P1;
        end
      end
      S_PAUSED: begin
        if (w_start_ev) w_next_state = r_who ? S_RUN_P2 : S_RUN_P1;
      end
      S_TIMEOUT: begin
        w_next_state = S_TIMEOUT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    w_run_now  = (r_state == S_RUN_P1) || (r_state == S_RUN_P2);
    w_run_next = (w_next_state == S_RUN_P1) || (w_next_state == S_RUN_P2);

    // The prescaler only advances while the same player keeps running; a resume from
    // pause keeps the held phase, any other entry into a run state restarts it.
    if (w_run_now && (w_next_state == r_state)) begin
      if (r_cnt == CNT_MAX) begin
        w_next_cnt = '0;
        w_wrap     = 1'b1;
      end else begin
        w_next_cnt = r_cnt + CNT_W'(1);
      end
    end else if (w_run_next && (w_next_state != r_state) && (r_state != S_PAUSED)) begin
      w_next_cnt = '0;
    end
  end

  always_comb begin
    w_active_p1  = 1'b0;
    w_active_p2  = 1'b0;
    w_running    = 1'b0;
    w_impulse_p1 = w_wrap && (r_state == S_RUN_P1);
    w_impulse_p2 = w_wrap && (r_state == S_RUN_P2);
    case (w_next_state)
      S_RUN_P1: begin
        w_active_p1 = 1'b1;
        w_running   = 1'b1;
      end
      S_RUN_P2: begin
        w_active_p2 = 1'b1;
        w_running   = 1'b1;
      end
      S_PAUSED: begin
        w_active_p1 = ~w_next_who;
        w_active_p2 = w_next_who;
      end
      S_TIMEOUT: begin
        w_active_p1 = w_next_flag_p1;
        w_active_p2 = w_next_flag_p2;
      end
      default: begin
        w_active_p1 = 1'b0;
        w_active_p2 = 1'b0;
      end
    endcase
  end

  assign IMPULSE_P1 = r_impulse_p1;
  assign IMPULSE_P2 = r_impulse_p2;
  assign ACTIVE_P1  = r_active_p1;
  assign ACTIVE_P2  = r_active_p2;
  assign RUNNING    = r_running;
  assign FLAG_P1    = r_flag_p1;
  assign FLAG_P2    = r_flag_p2;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Directed bench for chess_turn_controller with TICK_DIV=4; outputs are compared as the
// vector {ACTIVE_P1, ACTIVE_P2, RUNNING, FLAG_P1, FLAG_P2, IMPULSE_P1, IMPULSE_P2}.
module tb_chess_turn_controller;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic START = 1'b0;
  logic BTN_P1 = 1'b0;
  logic BTN_P2 = 1'b0;
  logic OVF_P1 = 1'b0;
  logic OVF_P2 = 1'b0;
  logic IMPULSE_P1, IMPULSE_P2, ACTIVE_P1, ACTIVE_P2, RUNNING, FLAG_P1, FLAG_P2;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // Reference vectors: RUN_P1, RUN_P2 (with/without pulse), PAUSED(P2), TIMEOUT P1/P2.
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_RUN1   = 7'b1010000;
  localparam logic [6:0] O_RUN1_I = 7'b1010010;
  localparam logic [6:0] O_RUN2   = 7'b0110000;
  localparam logic [6:0] O_RUN2_I = 7'b0110001;
  localparam logic [6:0] O_PAUSE2 = 7'b0100000;
  localparam logic [6:0] O_TOUT1  = 7'b1001000;
  localparam logic [6:0] O_TOUT2  = 7'b0100100;

  chess_turn_controller #(.TICK_DIV(4)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
    .OVF_P1(OVF_P1), .OVF_P2(OVF_P2),
    .IMPULSE_P1(IMPULSE_P1), .IMPULSE_P2(IMPULSE_P2),
    .ACTIVE_P1(ACTIVE_P1), .ACTIVE_P2(ACTIVE_P2), .RUNNING(RUNNING),
    .FLAG_P1(FLAG_P1), .FLAG_P2(FLAG_P2)
  );

  assign outs = {ACTIVE_P1, ACTIVE_P2, RUNNING, FLAG_P1, FLAG_P2, IMPULSE_P1, IMPULSE_P2};

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog outs=%b required=finish", outs);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_async outs=%b required=%b", outs, O_IDLE); end
    tick(2);
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_held outs=%b required=%b", outs, O_IDLE); end
    CLR = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_idle outs=%b required=%b", outs, O_IDLE); end
  endtask

  task automatic test_start;
    logic [6:0] exp_v;
    START = 1'b1;
    tick(2);
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL start_latency outs=%b required=%b", outs, O_IDLE); end
    tick(1);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL start_entry outs=%b required=%b", outs, O_RUN1); end
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 2) START = 1'b0;
      exp_v = (k % 4 == 0) ? O_RUN1_I : O_RUN1;
      checks++;
      if (outs !== exp_v) begin errors++; $display("FAIL start_pulses k=%0d outs=%b required=%b", k, outs, exp_v); end
    end
  endtask

  task automatic test_switch;
    logic [6:0] exp_v;
    BTN_P2 = 1'b1;
    tick(1);
    BTN_P2 = 1'b0;
    tick(3);
    checks++;
    if (outs !== O_RUN1_I) begin errors++; $display("FAIL ignore_btn_p2 outs=%b required=%b", outs, O_RUN1_I); end
    BTN_P1 = 1'b1;
    tick(1);
    BTN_P1 = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL switch_latency outs=%b required=%b", outs, O_RUN1); end
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL switch_entry outs=%b required=%b", outs, O_RUN2); end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      exp_v = (k == 4) ? O_RUN2_I : O_RUN2;
      checks++;
      if (outs !== exp_v) begin errors++; $display("FAIL switch_first_pulse k=%0d outs=%b required=%b", k, outs, exp_v); end
    end
  endtask

  task automatic test_pause;
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL pause_latency outs=%b required=%b", outs, O_RUN2); end
    tick(1);
    checks++;
    if (outs !== O_PAUSE2) begin errors++; $display("FAIL pause_entry outs=%b required=%b", outs, O_PAUSE2); end
    BTN_P2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 1) BTN_P2 = 1'b0;
      if (k == 5) OVF_P2 = 1'b1;
      if (k == 9) OVF_P2 = 1'b0;
      checks++;
      if (outs !== O_PAUSE2) begin errors++; $display("FAIL pause_hold k=%0d outs=%b required=%b", k, outs, O_PAUSE2); end
    end
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_PAUSE2) begin errors++; $display("FAIL resume_latency outs=%b required=%b", outs, O_PAUSE2); end
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL resume_entry outs=%b required=%b", outs, O_RUN2); end
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL resume_count outs=%b required=%b", outs, O_RUN2); end
    tick(1);
    checks++;
    if (outs !== O_RUN2_I) begin errors++; $display("FAIL resume_pulse outs=%b required=%b", outs, O_RUN2_I); end
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL resume_after outs=%b required=%b", outs, O_RUN2); end
  endtask

  task automatic test_wrap_switch;
    logic [6:0] exp_v;
    BTN_P2 = 1'b1;
    tick(1);
    BTN_P2 = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL wrap_pre outs=%b required=%b", outs, O_RUN2); end
    tick(1);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL wrap_suppress outs=%b required=%b", outs, O_RUN1); end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      exp_v = (k == 4) ? O_RUN1_I : O_RUN1;
      checks++;
      if (outs !== exp_v) begin errors++; $display("FAIL wrap_restart k=%0d outs=%b required=%b", k, outs, exp_v); end
    end
  endtask

  task automatic test_timeout;
    OVF_P1 = 1'b1;
    tick(1);
    OVF_P1 = 1'b0;
    checks++;
    if (outs !== O_TOUT1) begin errors++; $display("FAIL timeout_entry outs=%b required=%b", outs, O_TOUT1); end
    for (int i = 0; i < 30; i++) begin
      START  = (i % 6 == 0);
      BTN_P1 = (i % 6 == 2);
      BTN_P2 = (i % 6 == 4);
      OVF_P2 = (i >= 10 && i < 14);
      tick(1);
      checks++;
      if (outs !== O_TOUT1) begin errors++; $display("FAIL timeout_hold i=%0d outs=%b required=%b", i, outs, O_TOUT1); end
    end
    START = 1'b0; BTN_P1 = 1'b0; BTN_P2 = 1'b0; OVF_P2 = 1'b0;
    tick(2);
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL timeout_clr outs=%b required=%b", outs, O_IDLE); end
    tick(1);
    CLR = 1'b0;
    tick(1);
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL idle_after_clr outs=%b required=%b", outs, O_IDLE); end
  endtask

  task automatic test_priority;
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(2);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL prio_run1 outs=%b required=%b", outs, O_RUN1); end
    BTN_P1 = 1'b1;
    tick(1);
    BTN_P1 = 1'b0;
    tick(2);
    checks++;
    if (outs !== O_RUN2) begin errors++; $display("FAIL prio_run2 outs=%b required=%b", outs, O_RUN2); end
    START = 1'b1;
    BTN_P2 = 1'b1;
    tick(1);
    START = 1'b0;
    BTN_P2 = 1'b0;
    tick(1);
    OVF_P2 = 1'b1;
    tick(1);
    OVF_P2 = 1'b0;
    checks++;
    if (outs !== O_TOUT2) begin errors++; $display("FAIL prio_ovf_wins outs=%b required=%b", outs, O_TOUT2); end
    tick(3);
    checks++;
    if (outs !== O_TOUT2) begin errors++; $display("FAIL prio_flag_sticky outs=%b required=%b", outs, O_TOUT2); end
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    tick(1);
  endtask

  task automatic test_async_clr;
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(2);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL pre_clr_run outs=%b required=%b", outs, O_RUN1); end
    tick(1);
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL async_clr outs=%b required=%b", outs, O_IDLE); end
    tick(1);
    CLR = 1'b0;
    BTN_P1 = 1'b1;
    tick(1);
    BTN_P1 = 1'b0;
    tick(4);
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL btn_in_idle outs=%b required=%b", outs, O_IDLE); end
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(2);
    checks++;
    if (outs !== O_RUN1) begin errors++; $display("FAIL restart outs=%b required=%b", outs, O_RUN1); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_switch();
    test_pause();
    test_wrap_switch();
    test_timeout();
    test_priority();
    test_async_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
